// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and helpers for the two-master register bank arbiter.
// Holds the data/byte-lane widths, the FSM state encoding and the arbitration rule.
package reg_bank_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef logic master_t;

  localparam master_t M0 = 1'b0;
  localparam master_t M1 = 1'b1;

  // Round-robin between two masters: on a tie, the one not served last wins.
  function automatic master_t pick_master(input logic    req0,
                                          input logic    req1,
                                          input master_t last_grant);
    if (req0 && req1) return master_t'(~last_grant);
    else if (req1)    return M1;
    else              return M0;
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] new_word,
                                                    input logic [BE_W-1:0]   byteenable);
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (byteenable[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_bank_word.sv
// One byte-writable 32-bit register of the shared bank.
// Byte lanes without their enable bit hold their previous contents.
module bank_word
  import reg_bank_arbiter_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              write_strobe,
  input  logic [BE_W-1:0]   byteenable,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] q
);

  // NOTE: state is updated with <= so every flop samples pre-edge values,
  // independent of the order in which always_ff blocks are evaluated.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the bank is built from flops and is cleared on reset because the
      // datapath reads reg_q continuously; an unreset RAM would expose X.
      q <= '0;
    end else if (write_strobe) begin
      q <= merge_bytes(q, writedata, byteenable);
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by two masters through a req/ack handshake with
// round-robin arbitration; one IDLE -> ACCESS -> DONE transaction at a time.
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                       clock,
  input  logic                       reset,

  input  logic                       m0_req,
  input  logic                       m0_write,
  input  logic [ADDR_W-1:0]          m0_addr,
  input  logic [BE_W-1:0]            m0_byteenable,
  input  logic [DATA_W-1:0]          m0_writedata,
  output logic [DATA_W-1:0]          m0_readdata,
  output logic                       m0_ack,

  input  logic                       m1_req,
  input  logic                       m1_write,
  input  logic [ADDR_W-1:0]          m1_addr,
  input  logic [BE_W-1:0]            m1_byteenable,
  input  logic [DATA_W-1:0]          m1_writedata,
  output logic [DATA_W-1:0]          m1_readdata,
  output logic                       m1_ack,

  output logic                       busy,
  output logic [DATA_W*NUM_REGS-1:0] reg_q
);

  if (ADDR_W != ((NUM_REGS > 1) ? $clog2(NUM_REGS) : 1)) begin : g_bad_addr_w
    $error("reg_bank_arbiter: ADDR_W does not match NUM_REGS");
  end

  state_t            state;
  state_t            state_nxt;
  master_t           grant;
  master_t           last_grant;
  master_t           grant_nxt;
  logic              any_req;

  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [BE_W-1:0]   cmd_be;
  logic [DATA_W-1:0] cmd_data;

  logic [DATA_W-1:0] bank_q [NUM_REGS];
  logic [DATA_W-1:0] rd_word;

  assign any_req   = m0_req | m1_req;
  assign grant_nxt = pick_master(m0_req, m1_req, last_grant);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE:   if (any_req) state_nxt = ACCESS;
      ACCESS: state_nxt = DONE;
      DONE: begin
        m0_ack    = (grant == M0);
        m1_ack    = (grant == M1);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Commands are captured at grant so the masters may change their fields later.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant      <= M0;
      last_grant <= M1;
      cmd_write  <= 1'b0;
      cmd_addr   <= '0;
      cmd_be     <= '0;
      cmd_data   <= '0;
    end else if (state == IDLE && any_req) begin
      grant      <= grant_nxt;
      last_grant <= grant_nxt;
      cmd_write  <= (grant_nxt == M1) ? m1_write      : m0_write;
      cmd_addr   <= (grant_nxt == M1) ? m1_addr       : m0_addr;
      cmd_be     <= (grant_nxt == M1) ? m1_byteenable : m0_byteenable;
      cmd_data   <= (grant_nxt == M1) ? m1_writedata  : m0_writedata;
    end
  end

  // An address with no matching word selects nothing, so reads return zero.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (cmd_addr == ADDR_W'(k)) rd_word = bank_q[k];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m0_readdata <= '0;
      m1_readdata <= '0;
    end else if (state == ACCESS && !cmd_write) begin
      if (grant == M0) m0_readdata <= rd_word;
      else             m1_readdata <= rd_word;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_word
    logic write_strobe;

    assign write_strobe = (state == ACCESS) && cmd_write && (cmd_addr == ADDR_W'(k));

    bank_word u_word (
      .clock        (clock),
      .reset        (reset),
      .write_strobe (write_strobe),
      .byteenable   (cmd_be),
      .writedata    (cmd_data),
      .q            (bank_q[k])
    );

    assign reg_q[DATA_W*k +: DATA_W] = bank_q[k];
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter with a three-register bank, so that
// address 3 exercises the out-of-range path.
module tb_reg_bank_arbiter;

  localparam int NREGS = 3;
  localparam int AW    = 2;

  typedef struct {
    logic        is_read;
    logic [31:0] rdata;
    int          ack_cycle;
  } sb_entry_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req   [2];
  logic              wr    [2];
  logic [AW-1:0]     addr  [2];
  logic [3:0]        be    [2];
  logic [31:0]       wdata [2];
  logic [31:0]       rd    [2];
  logic              ack   [2];
  logic              busy;
  logic [32*NREGS-1:0] reg_q;

  sb_entry_t   sb0[$];
  sb_entry_t   sb1[$];
  sb_entry_t   mon_e;
  logic        mon_has;
  logic [31:0] model   [NREGS];
  logic [31:0] last_rd [2];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;

  reg_bank_arbiter #(.NUM_REGS(NREGS), .ADDR_W(AW)) dut (
    .clock         (clock),
    .reset         (reset),
    .m0_req        (req[0]),
    .m0_write      (wr[0]),
    .m0_addr       (addr[0]),
    .m0_byteenable (be[0]),
    .m0_writedata  (wdata[0]),
    .m0_readdata   (rd[0]),
    .m0_ack        (ack[0]),
    .m1_req        (req[1]),
    .m1_write      (wr[1]),
    .m1_addr       (addr[1]),
    .m1_byteenable (be[1]),
    .m1_writedata  (wdata[1]),
    .m1_readdata   (rd[1]),
    .m1_ack        (ack[1]),
    .busy          (busy),
    .reg_q         (reg_q)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void clear_model();
    for (int k = 0; k < NREGS; k++) model[k] = '0;
    last_rd[0] = '0;
    last_rd[1] = '0;
  endfunction

  function automatic logic [31:0] model_rd(input logic [AW-1:0] a);
    return (int'(a) < NREGS) ? model[a] : 32'h0;
  endfunction

  task automatic check_regs(input string tag);
    for (int k = 0; k < NREGS; k++)
      check($sformatf("%s_reg%0d", tag, k), reg_q[32*k +: 32], model[k]);
  endtask

  task automatic check_idle(input string tag);
    check_regs(tag);
    check({tag, "_ack0"}, 32'(ack[0]), 32'h0);
    check({tag, "_ack1"}, 32'(ack[1]), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_rd0"}, rd[0], 32'h0);
    check({tag, "_rd1"}, rd[1], 32'h0);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    req[0] = 1'b0;
    req[1] = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    clear_model();
  endtask

  // Issues one transaction and pushes its expected completion to the scoreboard.
  // lat is the number of cycles from the issuing cycle to the ack cycle.
  task automatic run_txn(input int m, input logic w, input logic [AW-1:0] a,
                         input logic [3:0] b, input logic [31:0] d,
                         input logic [31:0] exp_rd, input int lat, input bit keep);
    sb_entry_t e;
    bit        got;
    e.is_read   = !w;
    e.rdata     = exp_rd;
    e.ack_cycle = cyc + lat;
    if (m == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    if (w && int'(a) < NREGS)
      for (int i = 0; i < 4; i++)
        if (b[i]) model[a][8*i +: 8] = d[8*i +: 8];
    wr[m]    = w;
    addr[m]  = a;
    be[m]    = b;
    wdata[m] = d;
    req[m]   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      if (ack[m] === 1'b1) got = 1'b1;
    end
    check($sformatf("ack_seen_m%0d", m), 32'(got), 32'h1);
    @(posedge clock);
    #1 if (!keep) req[m] = 1'b0;
  endtask

  // Monitor: every ack must match the oldest pending entry of that master.
  initial begin
    forever begin
      @(negedge clock);
      for (int m = 0; m < 2; m++) begin
        if (ack[m] === 1'b1) begin
          mon_has = (m == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
          check($sformatf("expected_ack_m%0d", m), 32'(mon_has), 32'h1);
          if (mon_has) begin
            mon_e = (m == 0) ? sb0.pop_front() : sb1.pop_front();
            check($sformatf("ack_cycle_m%0d", m), cyc, mon_e.ack_cycle);
            if (mon_e.is_read) begin
              check($sformatf("readdata_m%0d", m), rd[m], mon_e.rdata);
              last_rd[m] = mon_e.rdata;
            end
          end
          check($sformatf("other_ack_m%0d", 1 - m), 32'(ack[1-m]), 32'h0);
          check($sformatf("other_rd_hold_m%0d", 1 - m), rd[1-m], last_rd[1-m]);
          check("busy_in_done", 32'(busy), 32'h1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; wr[m] = 1'b0; addr[m] = '0; be[m] = '0; wdata[m] = '0;
    end
    clear_model();

    do_reset();
    check_idle("reset");

    // Byte lanes, a no-op write and a read-back, issued back to back by m0.
    run_txn(0, 1'b1, 2'd1, 4'b1111, 32'hAABBCCDD, 32'h0, 2, 1'b0);
    check_regs("full_write");
    run_txn(0, 1'b1, 2'd1, 4'b0101, 32'h11223344, 32'h0, 2, 1'b0);
    check_regs("lane_write");
    run_txn(0, 1'b1, 2'd1, 4'b0000, 32'hDEADBEEF, 32'h0, 2, 1'b0);
    check_regs("be0_write");
    run_txn(0, 1'b0, 2'd1, 4'b1111, 32'h0, model_rd(2'd1), 2, 1'b0);

    // Continuous contention right after reset: m0 first, then strict alternation.
    do_reset();
    fork
      begin
        run_txn(0, 1'b1, 2'd0, 4'b1111, 32'h1, 32'h0, 2, 1'b1);
        run_txn(0, 1'b1, 2'd0, 4'b1111, 32'h2, 32'h0, 5, 1'b1);
        run_txn(0, 1'b1, 2'd0, 4'b1111, 32'h3, 32'h0, 5, 1'b0);
      end
      begin
        run_txn(1, 1'b0, 2'd0, 4'b1111, 32'h0, 32'h1, 5, 1'b1);
        run_txn(1, 1'b0, 2'd0, 4'b1111, 32'h0, 32'h2, 5, 1'b1);
        run_txn(1, 1'b0, 2'd0, 4'b1111, 32'h0, 32'h3, 5, 1'b0);
      end
    join
    check_regs("contention");

    // Address beyond the bank: write discarded, read returns zero.
    run_txn(1, 1'b1, 2'd3, 4'b1111, 32'h55555555, 32'h0, 2, 1'b0);
    check_regs("oob_write");
    run_txn(1, 1'b0, 2'd3, 4'b1111, 32'h0, model_rd(2'd3), 2, 1'b0);

    // Reset while the write is in ACCESS: no ack, no write.
    wr[0]    = 1'b1;
    addr[0]  = 2'd2;
    be[0]    = 4'b1111;
    wdata[0] = 32'hFFFFFFFF;
    req[0]   = 1'b1;
    @(posedge clock);
    #1 check("abort_busy", 32'(busy), 32'h1);
    reset  = 1'b1;
    req[0] = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    clear_model();
    repeat (4) @(posedge clock);
    #1 check_idle("abort");
    run_txn(0, 1'b1, 2'd2, 4'b1111, 32'h12345678, 32'h0, 2, 1'b0);
    check_regs("after_abort");

    repeat (3) @(posedge clock);
    check("sb_drain", 32'(sb0.size() + sb1.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
